// File: rtl/fractal_color_pkg.sv
// Shared types for the fractal colouriser: colour modes, video sideband bundle
// and pixel pack/unpack helpers (channel width given at call time, up to MAX_CW).
package fractal_color_pkg;

    typedef enum logic [3:0] {
        M_GRAY    = 4'd0,
        M_RED     = 4'd1,
        M_GREEN   = 4'd2,
        M_BLUE    = 4'd3,
        M_YELLOW  = 4'd4,
        M_CYAN    = 4'd5,
        M_MAGENTA = 4'd6,
        M_PALETTE = 4'd7
    } mode_t;

    localparam mode_t MODE_DEFAULT = M_GRAY;
    localparam int    MAX_CW       = 16;

    typedef struct packed {
        logic fs;
        logic le;
        logic de;
    } sb_t;

    typedef struct packed {
        logic [MAX_CW-1:0] ch2;
        logic [MAX_CW-1:0] ch1;
        logic [MAX_CW-1:0] ch0;
    } rgb_t;

    // Packs three channels as {ch2, ch1, ch0}, each cw bits wide, LSB-aligned.
    function automatic logic [3*MAX_CW-1:0] pack_px(input rgb_t c, input int cw);
        logic [MAX_CW-1:0] mask;
        mask = MAX_CW'((1 << cw) - 1);
        return (3*MAX_CW)'(c.ch0 & mask)
             | ((3*MAX_CW)'(c.ch1 & mask) << cw)
             | ((3*MAX_CW)'(c.ch2 & mask) << (2*cw));
    endfunction

    function automatic rgb_t unpack_px(input logic [3*MAX_CW-1:0] p, input int cw);
        rgb_t c;
        logic [MAX_CW-1:0] mask;
        mask  = MAX_CW'((1 << cw) - 1);
        c.ch0 = MAX_CW'(p) & mask;
        c.ch1 = MAX_CW'(p >> cw) & mask;
        c.ch2 = MAX_CW'(p >> (2*cw)) & mask;
        return c;
    endfunction

endpackage

// File: rtl/fractal_palette_mapper_if.sv
// Pixel stream, control and palette-write signals of the fractal palette mapper.
interface fractal_palette_mapper_if #(
    parameter int ITER_WIDTH  = 8,
    parameter int COLOR_WIDTH = 8
);
    logic [3:0]               mode;
    logic [ITER_WIDTH-1:0]    cycle_step;
    logic [ITER_WIDTH-1:0]    data_in;
    logic                     frame_start_in;
    logic                     line_end_in;
    logic                     data_enable_in;
    logic                     pal_wr_en;
    logic [ITER_WIDTH-1:0]    pal_wr_addr;
    logic [3*COLOR_WIDTH-1:0] pal_wr_data;
    logic                     pal_commit;
    logic                     pal_commit_pending;
    logic [3*COLOR_WIDTH-1:0] data_out;
    logic                     frame_start_out;
    logic                     line_end_out;
    logic                     data_enable_out;

    modport master (
        output mode, cycle_step, data_in, frame_start_in, line_end_in, data_enable_in,
               pal_wr_en, pal_wr_addr, pal_wr_data, pal_commit,
        input  pal_commit_pending, data_out, frame_start_out, line_end_out, data_enable_out
    );

    modport slave (
        input  mode, cycle_step, data_in, frame_start_in, line_end_in, data_enable_in,
               pal_wr_en, pal_wr_addr, pal_wr_data, pal_commit,
        output pal_commit_pending, data_out, frame_start_out, line_end_out, data_enable_out
    );
endinterface

// File: rtl/fractal_palette_ram.sv
// Two-bank palette RAM: one write port, one registered read port, bank chosen per port.
module fractal_palette_ram #(
    parameter int AW = 8,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [0:(2<<AW)-1];

    // Read returns the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
        rd_data <= mem[{rd_bank, rd_addr}];
    end
endmodule

// File: rtl/fractal_palette_mapper.sv
// Iteration count -> RGB colouriser, 2-cycle latency, double-buffered palette.
// Define FRACTAL_PALETTE_CYCLE_EN to enable per-frame palette rotation.
module fractal_palette_mapper
    import fractal_color_pkg::*;
#(
    parameter int ITER_WIDTH  = 8,
    parameter int COLOR_WIDTH = 8
) (
    input logic clk,
    input logic resetn,
    fractal_palette_mapper_if.slave bus
);
    localparam int PW     = 3*COLOR_WIDTH;
    localparam int STAGES = 2;

    logic [3:0]             act_mode, mode_eff, mode_q;
    logic                   front, front_eff, pending, swap;
    logic [ITER_WIDTH-1:0]  off_eff, rd_addr;
    logic [COLOR_WIDTH-1:0] v_d, v_q;
    logic [PW-1:0]          pal_q, data_d, data_q;
    logic [3*MAX_CW-1:0]    px_wide;
    logic                   unused_px;
    rgb_t                   px_c;
    sb_t                    sb_in;
    sb_t [STAGES:1]         sb_pipe;

    // Short counts are repeated MSB-first so full scale stays full scale.
    function automatic logic [COLOR_WIDTH-1:0] scale_v(input logic [ITER_WIDTH-1:0] d);
        logic [COLOR_WIDTH-1:0] s;
        for (int i = 0; i < COLOR_WIDTH; i++)
            s[COLOR_WIDTH-1-i] = d[ITER_WIDTH-1-(i % ITER_WIDTH)];
        return s;
    endfunction

    // Frame-start updates already apply to the pixel that carries frame_start_in.
    always_comb begin
        mode_eff  = bus.frame_start_in ? bus.mode : act_mode;
        swap      = bus.frame_start_in & (pending | bus.pal_commit);
        front_eff = front ^ swap;
        rd_addr   = bus.data_in + off_eff;
        v_d       = scale_v(bus.data_in);
        sb_in     = '{fs: bus.frame_start_in, le: bus.line_end_in, de: bus.data_enable_in};
    end

`ifdef FRACTAL_PALETTE_CYCLE_EN
    logic [ITER_WIDTH-1:0] offset;

    assign off_eff = bus.frame_start_in ? offset + bus.cycle_step : offset;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) offset <= '0;
        else         offset <= off_eff;
    end
`else
    logic unused_step;

    assign off_eff     = '0;
    assign unused_step = ^bus.cycle_step;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            act_mode <= MODE_DEFAULT;
            front    <= 1'b0;
            pending  <= 1'b0;
        end else begin
            act_mode <= mode_eff;
            front    <= front_eff;
            pending  <= bus.frame_start_in ? 1'b0 : (pending | bus.pal_commit);
        end
    end

    // Writes target the bank behind the pre-swap front.
    fractal_palette_ram #(.AW(ITER_WIDTH), .DW(PW)) u_ram (
        .clk     (clk),
        .wr_en   (bus.pal_wr_en),
        .wr_bank (~front),
        .wr_addr (bus.pal_wr_addr),
        .wr_data (bus.pal_wr_data),
        .rd_bank (front_eff),
        .rd_addr (rd_addr),
        .rd_data (pal_q)
    );

    always_comb begin
        px_c = '0;
        case (mode_q)
            M_RED:     px_c.ch2 = MAX_CW'(v_q);
            M_GREEN:   px_c.ch0 = MAX_CW'(v_q);
            M_BLUE:    px_c.ch1 = MAX_CW'(v_q);
            M_YELLOW:  begin px_c.ch2 = MAX_CW'(v_q); px_c.ch0 = MAX_CW'(v_q); end
            M_CYAN:    begin px_c.ch1 = MAX_CW'(v_q); px_c.ch0 = MAX_CW'(v_q); end
            M_MAGENTA: begin px_c.ch2 = MAX_CW'(v_q); px_c.ch1 = MAX_CW'(v_q); end
            M_PALETTE: px_c = '0;
            default:   px_c = '{ch2: MAX_CW'(v_q), ch1: MAX_CW'(v_q), ch0: MAX_CW'(v_q)};
        endcase
        px_wide = pack_px(px_c, COLOR_WIDTH);
        data_d  = (mode_q == M_PALETTE) ? pal_q : px_wide[PW-1:0];
    end

    assign unused_px = ^px_wide;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q  <= MODE_DEFAULT;
            v_q     <= '0;
            sb_pipe <= '0;
            data_q  <= '0;
        end else begin
            mode_q  <= mode_eff;
            v_q     <= v_d;
            sb_pipe <= {sb_pipe[STAGES-1:1], sb_in};
            data_q  <= data_d;
        end
    end

    assign bus.data_out           = data_q;
    assign bus.frame_start_out    = sb_pipe[STAGES].fs;
    assign bus.line_end_out       = sb_pipe[STAGES].le;
    assign bus.data_enable_out    = sb_pipe[STAGES].de;
    assign bus.pal_commit_pending = pending;
endmodule

// File: tb/tb_fractal_palette_mapper.sv
// Scoreboard bench for fractal_palette_mapper; follows FRACTAL_PALETTE_CYCLE_EN like the DUT.
module tb_fractal_palette_mapper;
    localparam int IW = 8;
    localparam int CW = 8;
    localparam int PW = 3*CW;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fractal_palette_mapper_if #(.ITER_WIDTH(IW), .COLOR_WIDTH(CW)) bus ();
    fractal_palette_mapper_if #(.ITER_WIDTH(4),  .COLOR_WIDTH(8))  bus4 ();
    fractal_palette_mapper_if #(.ITER_WIDTH(10), .COLOR_WIDTH(8))  bus10 ();

    fractal_palette_mapper #(.ITER_WIDTH(IW), .COLOR_WIDTH(CW)) dut (.clk(clk), .resetn(resetn), .bus(bus));
    fractal_palette_mapper #(.ITER_WIDTH(4),  .COLOR_WIDTH(8))  u4  (.clk(clk), .resetn(resetn), .bus(bus4));
    fractal_palette_mapper #(.ITER_WIDTH(10), .COLOR_WIDTH(8))  u10 (.clk(clk), .resetn(resetn), .bus(bus10));

    typedef struct {
        logic [PW-1:0] data;
        logic fs, le, de;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [3:0]    m_mode;
    logic          m_front, m_pend;
    logic [IW-1:0] m_off;
    logic [PW-1:0] pal_m [2][256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] colour(input logic [3:0] m, input logic [7:0] v, input logic [PW-1:0] p);
        case (m)
            4'd1:    return {v, 8'h00, 8'h00};
            4'd2:    return {16'h0000, v};
            4'd3:    return {8'h00, v, 8'h00};
            4'd4:    return {v, 8'h00, v};
            4'd5:    return {8'h00, v, v};
            4'd6:    return {v, v, 8'h00};
            4'd7:    return p;
            default: return {v, v, v};
        endcase
    endfunction

    // Predict the pixel currently on the inputs, advance one clock, then check.
    task automatic step();
        exp_t          e;
        logic          fs, sw, rb;
        logic [3:0]    em;
        logic [IW-1:0] off_n, a;
        fs = bus.frame_start_in;
        em = fs ? bus.mode : m_mode;
        sw = fs & (m_pend | bus.pal_commit);
        rb = m_front ^ sw;
`ifdef FRACTAL_PALETTE_CYCLE_EN
        off_n = fs ? m_off + bus.cycle_step : m_off;
`else
        off_n = '0;
`endif
        a = bus.data_in + off_n;
        e.data = colour(em, bus.data_in, pal_m[rb][a]);
        e.fs = fs;
        e.le = bus.line_end_in;
        e.de = bus.data_enable_in;
        sb_q.push_back(e);
        if (bus.pal_wr_en) pal_m[!m_front][bus.pal_wr_addr] = bus.pal_wr_data;
        m_mode  = em;
        m_front = rb;
        m_pend  = fs ? 1'b0 : (m_pend | bus.pal_commit);
        m_off   = off_n;
        @(negedge clk);
        chk("pending", 32'(bus.pal_commit_pending), 32'(m_pend));
        if (sb_q.size() > 1) begin
            e = sb_q.pop_front();
            chk("fs_out", 32'(bus.frame_start_out), 32'(e.fs));
            chk("le_out", 32'(bus.line_end_out), 32'(e.le));
            chk("de_out", 32'(bus.data_enable_out), 32'(e.de));
            if (e.de) chk("data_out", 32'(bus.data_out), 32'(e.data));
        end
    endtask

    task automatic idle();
        bus.frame_start_in = 0; bus.line_end_in = 0; bus.data_enable_in = 0;
        bus.data_in = '0; bus.pal_wr_en = 0; bus.pal_commit = 0; bus.cycle_step = '0;
    endtask

    task automatic px(input logic [3:0] md, input logic fs, input logic [7:0] d,
                      input logic commit = 1'b0, input logic [7:0] cstep = 8'd0);
        bus.mode = md; bus.frame_start_in = fs; bus.line_end_in = 1'b0; bus.data_enable_in = 1'b1;
        bus.data_in = d; bus.pal_commit = commit; bus.cycle_step = cstep; bus.pal_wr_en = 1'b0;
        step();
    endtask

    task automatic wr(input logic [7:0] addr, input logic [PW-1:0] d);
        idle();
        bus.pal_wr_en = 1'b1; bus.pal_wr_addr = addr; bus.pal_wr_data = d;
        step();
        bus.pal_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        exp_t z;
        @(negedge clk);
        idle();
        resetn = 1'b0;
        #1;
        chk("rst_data", 32'(bus.data_out), 32'h0);
        chk("rst_fs", 32'(bus.frame_start_out), 32'h0);
        chk("rst_de", 32'(bus.data_enable_out), 32'h0);
        chk("rst_pend", 32'(bus.pal_commit_pending), 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_mode = 4'd0; m_front = 1'b0; m_pend = 1'b0; m_off = '0;
        sb_q.delete();
        z = '{data: '0, fs: 1'b0, le: 1'b0, de: 1'b0};
        sb_q.push_back(z);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       fs, cm;
        idle();
        bus.mode = 4'd0; bus.pal_wr_addr = '0; bus.pal_wr_data = '0;
        bus4.mode = 4'd0; bus4.cycle_step = '0; bus4.data_in = 4'hA; bus4.frame_start_in = 0;
        bus4.line_end_in = 0; bus4.data_enable_in = 1; bus4.pal_wr_en = 0; bus4.pal_wr_addr = '0;
        bus4.pal_wr_data = '0; bus4.pal_commit = 0;
        bus10.mode = 4'd0; bus10.cycle_step = '0; bus10.data_in = 10'h3FF; bus10.frame_start_in = 0;
        bus10.line_end_in = 0; bus10.data_enable_in = 1; bus10.pal_wr_en = 0; bus10.pal_wr_addr = '0;
        bus10.pal_wr_data = '0; bus10.pal_commit = 0;
        do_reset();

        // Known contents in both banks: fill bank 1, swap, fill bank 0.
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            wr(b, {b, ~b, b ^ 8'h5A});
        end
        idle(); bus.pal_commit = 1'b1; step();
        px(4'd0, 1'b1, 8'h00);
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            wr(b, {~b, b, 8'h33});
        end
        chk("gray_iw4_A", 32'(bus4.data_out), 32'hAAAAAA);
        chk("gray_iw10_3FF", 32'(bus10.data_out), 32'hFFFFFF);

        // Mid-stream reset, then RED frame.
        for (int k = 0; k < 6; k++) px(4'd0, k == 0, 8'($urandom));
        do_reset();
        px(4'd1, 1'b1, 8'h80);
        for (int k = 0; k < 3; k++) px(4'd3, 1'b0, 8'h40 + 8'(k));

        // Mode change mid-frame only takes effect at the next frame start.
        px(4'd4, 1'b0, 8'h21); px(4'd4, 1'b0, 8'h22);
        px(4'd4, 1'b1, 8'h21); px(4'd4, 1'b0, 8'h9C);
        px(4'hB, 1'b1, 8'h77); px(4'd1, 1'b0, 8'h78);
        for (int m = 0; m < 16; m++) begin
            px(4'(m), 1'b1, 8'($urandom));
            px(4'(m) ^ 4'd5, 1'b0, 8'($urandom));
        end

        // Deferred commit: old front until the next frame start.
        px(4'd7, 1'b1, 8'd5);
        wr(8'd5, 24'h123456);
        idle(); bus.pal_commit = 1'b1; step();
        px(4'd7, 1'b0, 8'd5); px(4'd7, 1'b0, 8'd5);
        px(4'd7, 1'b1, 8'd5); px(4'd7, 1'b0, 8'd5);

        // Commit coinciding with frame start swaps on that very pixel.
        wr(8'd9, 24'hABCDEF);
        px(4'd7, 1'b1, 8'd9, 1'b1); px(4'd7, 1'b0, 8'd9);

        // Rotation: offset to 254, then +3 wraps to 1.
        px(4'd7, 1'b1, 8'd0, 1'b0, 8'd254); px(4'd7, 1'b0, 8'd0);
        px(4'd7, 1'b1, 8'd0, 1'b0, 8'd3);   px(4'd7, 1'b0, 8'd0);
        px(4'd7, 1'b0, 8'd255);

        bus4.data_in = 4'h5; bus10.data_in = 10'h200;
        repeat (3) step();
        chk("gray_iw4_5", 32'(bus4.data_out), 32'h555555);
        chk("gray_iw10_200", 32'(bus10.data_out), 32'h808080);

        // Random traffic; writes kept outside commit windows.
        for (int k = 0; k < 400; k++) begin
            fs = ($urandom_range(0, 19) == 0);
            cm = ($urandom_range(0, 49) == 0);
            bus.mode = 4'($urandom); bus.frame_start_in = fs;
            bus.line_end_in = 1'($urandom); bus.data_enable_in = ($urandom_range(0, 3) != 0);
            bus.data_in = 8'($urandom); bus.pal_commit = cm; bus.cycle_step = 8'($urandom_range(0, 3));
            bus.pal_wr_en = !m_pend && !cm && !fs && ($urandom_range(0, 2) == 0);
            bus.pal_wr_addr = 8'($urandom); bus.pal_wr_data = 24'($urandom);
            step();
        end
        idle();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
